// File: rtl/mesh_term_pkg.sv
// Shared definitions for the mesh terminal bank: packet field layout,
// the packed packet view for the default width, and terminal addressing.
package mesh_term_pkg;

  localparam int NXT_W  = 8;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 4;
  localparam int MODE_W = 1;
  localparam int HDR_W  = NXT_W + ROW_W + COL_W + MODE_W;

  localparam int PCKG_SZ_DEF = 32;
  localparam int PW_DEF      = PCKG_SZ_DEF - HDR_W;

  typedef struct packed {
    logic [NXT_W-1:0] nxt_jump;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             mode;
    logic [PW_DEF-1:0] pyld;
  } pkt_t;

  function automatic int payload_width(input int pckg_sz);
    return pckg_sz - HDR_W;
  endfunction

  // Terminals are numbered top edge, left edge, bottom edge, right edge.
  function automatic logic [7:0] term_id(input int i, input int rows, input int cols);
    logic [3:0] r;
    logic [3:0] c;
    if (i < cols) begin
      r = 4'd0;
      c = 4'(i + 1);
    end else if (i < cols + rows) begin
      r = 4'(i - cols + 1);
      c = 4'd0;
    end else if (i < 2 * cols + rows) begin
      r = 4'(rows + 1);
      c = 4'(i - cols - rows + 1);
    end else begin
      r = 4'(i - 2 * cols - rows + 1);
      c = 4'(cols + 1);
    end
    return {r, c};
  endfunction

endpackage

// File: rtl/mesh_term_port.sv
// One mesh terminal: FWFT TX FIFO towards the router, RX FIFO towards the
// host, destination checker, traffic counters and sticky protocol flags.
module mesh_term_port
  import mesh_term_pkg::*;
#(
  parameter int          PCKG_SZ    = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 16,
  parameter logic [7:0]  ID         = 8'h01,
  parameter logic [7:0]  BDCST      = 8'hFF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  logic [ROW_W-1:0]            i_row,
  input  logic [COL_W-1:0]            i_col,
  input  logic                        i_mode,
  input  logic [PCKG_SZ-HDR_W-1:0]    i_pyld,
  output logic                        o_full,
  output logic [PCKG_SZ-1:0]          o_tx_data,
  output logic                        o_tx_pndng,
  input  logic                        i_pop,
  input  logic [PCKG_SZ-1:0]          i_rx_data,
  input  logic                        i_rx_pndng,
  output logic                        o_popin,
  output logic                        o_rx_valid,
  output logic [PCKG_SZ-1:0]          o_rx_head,
  input  logic                        i_rx_pop,
  output logic [CNT_W-1:0]            o_tx_cnt,
  output logic [CNT_W-1:0]            o_rx_cnt,
  output logic                        o_misroute_err,
  output logic                        o_proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = payload_width(PCKG_SZ);
  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(FIFO_DEPTH);

  logic [PCKG_SZ-1:0] r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_tx_wptr;
  logic [AW-1:0]      r_tx_rptr;
  logic [AW:0]        r_tx_count;
  logic [PCKG_SZ-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_rx_wptr;
  logic [AW-1:0]      r_rx_rptr;
  logic [AW:0]        r_rx_count;
  logic [CNT_W-1:0]   r_tx_cnt;
  logic [CNT_W-1:0]   r_rx_cnt;
  logic               r_misroute_err;
  logic               r_proto_err;

  logic               w_tx_full;
  logic               w_tx_empty;
  logic               w_rx_full;
  logic               w_rx_empty;
  logic               w_tx_wr;
  logic               w_tx_rd;
  logic               w_rx_wr;
  logic               w_rx_rd;
  logic [PCKG_SZ-1:0] w_tx_word;
  logic [7:0]         w_rx_dest;

  // Full/empty come from registered counts, so a pop in the same cycle never
  // frees room for a push (TX) or a router transfer (RX) until the next edge.
  assign w_tx_full  = (r_tx_count == LP_DEPTH);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == LP_DEPTH);
  assign w_rx_empty = (r_rx_count == '0);

  assign w_tx_wr = i_push & ~w_tx_full;
  assign w_tx_rd = i_pop & ~w_tx_empty;
  assign w_rx_wr = i_rx_pndng & ~w_rx_full;
  assign w_rx_rd = i_rx_pop & ~w_rx_empty;

  assign w_tx_word = {NXT_W'(0), i_row, i_col, i_mode, i_pyld[PW-1:0]};
  assign w_rx_dest = i_rx_data[PCKG_SZ-NXT_W-1 -: 8];

  always_ff @(posedge clk) begin
    if (w_tx_wr) r_tx_mem[r_tx_wptr] <= w_tx_word;
    if (w_rx_wr) r_rx_mem[r_rx_wptr] <= i_rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wptr      <= '0;
      r_tx_rptr      <= '0;
      r_tx_count     <= '0;
      r_rx_wptr      <= '0;
      r_rx_rptr      <= '0;
      r_rx_count     <= '0;
      r_tx_cnt       <= '0;
      r_rx_cnt       <= '0;
      r_misroute_err <= 1'b0;
      r_proto_err    <= 1'b0;
    end else begin
      if (w_tx_wr) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_rd) begin
        r_tx_rptr <= r_tx_rptr + 1'b1;
        r_tx_cnt  <= r_tx_cnt + 1'b1;
      end
      case ({w_tx_wr, w_tx_rd})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase

      if (w_rx_wr) begin
        r_rx_wptr <= r_rx_wptr + 1'b1;
        r_rx_cnt  <= r_rx_cnt + 1'b1;
        if ((w_rx_dest != ID) && (w_rx_dest != BDCST)) r_misroute_err <= 1'b1;
      end
      if (w_rx_rd) r_rx_rptr <= r_rx_rptr + 1'b1;
      case ({w_rx_wr, w_rx_rd})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase

      if ((i_pop && w_tx_empty) || (i_rx_pop && w_rx_empty)) r_proto_err <= 1'b1;
    end
  end

  assign o_full         = w_tx_full;
  assign o_tx_pndng     = ~w_tx_empty;
  assign o_tx_data      = w_tx_empty ? '0 : r_tx_mem[r_tx_rptr];
  assign o_popin        = w_rx_wr;
  assign o_rx_valid     = ~w_rx_empty;
  assign o_rx_head      = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr];
  assign o_tx_cnt       = r_tx_cnt;
  assign o_rx_cnt       = r_rx_cnt;
  assign o_misroute_err = r_misroute_err;
  assign o_proto_err    = r_proto_err;

endmodule

// File: rtl/mesh_term_array.sv
// Bank of independent mesh terminals attached to the outer ring of the router,
// one mesh_term_port per edge position, each addressed by its ring location.
module mesh_term_array
  import mesh_term_pkg::*;
#(
  parameter int         ROWS       = 4,
  parameter int         COLUMS     = 4,
  parameter int         pckg_sz    = 32,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] bdcst      = {8{1'b1}},
  parameter int         NTERM      = 2 * ROWS + 2 * COLUMS,
  parameter int         CNT_W      = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NTERM-1:0]                   in_push,
  input  logic [NTERM*ROW_W-1:0]             in_row,
  input  logic [NTERM*COL_W-1:0]             in_col,
  input  logic [NTERM-1:0]                   in_mode,
  input  logic [NTERM*(pckg_sz-HDR_W)-1:0]   in_pyld,
  output logic [NTERM-1:0]                   in_full,
  output logic [NTERM*pckg_sz-1:0]           data_out_i_in,
  output logic [NTERM-1:0]                   pndng_i_in,
  input  logic [NTERM-1:0]                   pop,
  input  logic [NTERM*pckg_sz-1:0]           data_out,
  input  logic [NTERM-1:0]                   pndng,
  output logic [NTERM-1:0]                   popin,
  output logic [NTERM-1:0]                   rx_valid,
  output logic [NTERM*pckg_sz-1:0]           rx_data,
  input  logic [NTERM-1:0]                   rx_pop,
  output logic [NTERM*CNT_W-1:0]             tx_cnt,
  output logic [NTERM*CNT_W-1:0]             rx_cnt,
  output logic [NTERM-1:0]                   misroute_err,
  output logic [NTERM-1:0]                   proto_err
);

  localparam int PW = pckg_sz - HDR_W;

  // Handshakes: a transfer happens on a rising edge where the producer's
  // valid (in_push, pndng_i_in, pndng, rx_valid) and the consumer's accept
  // (!in_full, pop, popin, rx_pop) are both high; valid never waits on accept.
  for (genvar g = 0; g < NTERM; g++) begin : g_term
    localparam logic [7:0] LP_ID = term_id(g, ROWS, COLUMS);

    mesh_term_port #(
      .PCKG_SZ    (pckg_sz),
      .FIFO_DEPTH (fifo_depth),
      .CNT_W      (CNT_W),
      .ID         (LP_ID),
      .BDCST      (bdcst)
    ) u_port (
      .clk            (clk),
      .reset          (reset),
      .i_push         (in_push[g]),
      .i_row          (in_row[g*ROW_W +: ROW_W]),
      .i_col          (in_col[g*COL_W +: COL_W]),
      .i_mode         (in_mode[g]),
      .i_pyld         (in_pyld[g*PW +: PW]),
      .o_full         (in_full[g]),
      .o_tx_data      (data_out_i_in[g*pckg_sz +: pckg_sz]),
      .o_tx_pndng     (pndng_i_in[g]),
      .i_pop          (pop[g]),
      .i_rx_data      (data_out[g*pckg_sz +: pckg_sz]),
      .i_rx_pndng     (pndng[g]),
      .o_popin        (popin[g]),
      .o_rx_valid     (rx_valid[g]),
      .o_rx_head      (rx_data[g*pckg_sz +: pckg_sz]),
      .i_rx_pop       (rx_pop[g]),
      .o_tx_cnt       (tx_cnt[g*CNT_W +: CNT_W]),
      .o_rx_cnt       (rx_cnt[g*CNT_W +: CNT_W]),
      .o_misroute_err (misroute_err[g]),
      .o_proto_err    (proto_err[g])
    );
  end

endmodule

// File: tb/tb_mesh_term_array.sv
// Directed bench for mesh_term_array: reset, TX format/flow control, RX
// backpressure, destination checking and protocol error flags.
module tb_mesh_term_array;

  localparam int NT = 16;
  localparam int PS = 32;
  localparam int PWD = 15;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NT-1:0]     in_push;
  logic [NT*4-1:0]   in_row;
  logic [NT*4-1:0]   in_col;
  logic [NT-1:0]     in_mode;
  logic [NT*PWD-1:0] in_pyld;
  logic [NT-1:0]     in_full;
  logic [NT*PS-1:0]  data_out_i_in;
  logic [NT-1:0]     pndng_i_in;
  logic [NT-1:0]     pop;
  logic [NT*PS-1:0]  data_out;
  logic [NT-1:0]     pndng;
  logic [NT-1:0]     popin;
  logic [NT-1:0]     rx_valid;
  logic [NT*PS-1:0]  rx_data;
  logic [NT-1:0]     rx_pop;
  logic [NT*CW-1:0]  tx_cnt;
  logic [NT*CW-1:0]  rx_cnt;
  logic [NT-1:0]     misroute_err;
  logic [NT-1:0]     proto_err;

  logic [PS-1:0] tx_q[$];
  logic [PS-1:0] rx_q[$];
  int n_cmp = 0;
  int n_err = 0;

  mesh_term_array dut (
    .clk(clk), .reset(reset), .in_push(in_push), .in_row(in_row), .in_col(in_col),
    .in_mode(in_mode), .in_pyld(in_pyld), .in_full(in_full), .data_out_i_in(data_out_i_in),
    .pndng_i_in(pndng_i_in), .pop(pop), .data_out(data_out), .pndng(pndng), .popin(popin),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
    .misroute_err(misroute_err), .proto_err(proto_err)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [PS-1:0] mk(input logic [3:0] r, input logic [3:0] c,
                                       input logic m, input logic [PWD-1:0] p);
    return {8'h00, r, c, m, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one host push on terminal t; the expected word joins tx_q only if accepted.
  task automatic push_tx(input int t, input logic [3:0] r, input logic [3:0] c,
                         input logic m, input logic [PWD-1:0] p, input bit expect_accept);
    in_row[t*4 +: 4]      = r;
    in_col[t*4 +: 4]      = c;
    in_mode[t]            = m;
    in_pyld[t*PWD +: PWD] = p;
    in_push[t]            = 1'b1;
    if (expect_accept && t == 0) tx_q.push_back(mk(r, c, m, p));
    tick();
    in_push[t] = 1'b0;
  endtask

  // Driver: router offers one packet to terminal t for a single cycle.
  task automatic deliver_rx(input int t, input logic [PS-1:0] pk, input string tag);
    data_out[t*PS +: PS] = pk;
    pndng[t]             = 1'b1;
    #1;
    check(tag, {63'd0, popin[t]}, 64'd1);
    if (popin[t]) rx_q.push_back(pk);
    tick();
    pndng[t] = 1'b0;
  endtask

  task automatic pop_tx_head(input int t, input string tag);
    logic [PS-1:0] e;
    if (tx_q.size() == 0) begin
      check({tag, "_q_empty"}, 64'd1, 64'd0);
      e = '0;
    end else e = tx_q.pop_front();
    check(tag, {32'd0, data_out_i_in[t*PS +: PS]}, {32'd0, e});
    pop[t] = 1'b1;
    tick();
    pop[t] = 1'b0;
  endtask

  task automatic pop_rx_head(input int t, input string tag);
    logic [PS-1:0] e;
    if (rx_q.size() == 0) begin
      check({tag, "_q_empty"}, 64'd1, 64'd0);
      e = '0;
    end else e = rx_q.pop_front();
    check(tag, {32'd0, rx_data[t*PS +: PS]}, {32'd0, e});
    rx_pop[t] = 1'b1;
    tick();
    rx_pop[t] = 1'b0;
  endtask

  initial begin
    int n;
    logic [PS-1:0] pk;
    reset = 1'b1;
    in_push = '0; in_row = '0; in_col = '0; in_mode = '0; in_pyld = '0;
    pop = '0; data_out = '0; pndng = '0; rx_pop = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check("rst_in_full", {48'd0, in_full}, 64'd0);
    check("rst_pndng_i_in", {48'd0, pndng_i_in}, 64'd0);
    check("rst_data_out_i_in", {32'd0, data_out_i_in[63:0] | data_out_i_in[511:448]}, 64'd0);
    check("rst_popin", {48'd0, popin}, 64'd0);
    check("rst_rx_valid", {48'd0, rx_valid}, 64'd0);
    check("rst_rx_data", rx_data[63:0], 64'd0);
    check("rst_tx_cnt", tx_cnt[63:0], 64'd0);
    check("rst_rx_cnt", rx_cnt[63:0], 64'd0);
    check("rst_errors", {32'd0, misroute_err, proto_err}, 64'd0);

    // Reset mid-traffic discards queued packets
    for (int i = 0; i < 3; i++) push_tx(0, 4'(i), 4'd1, 1'b0, 15'(i + 7), 1'b0);
    check("pre_reset_pndng", {63'd0, pndng_i_in[0]}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_pndng", {48'd0, pndng_i_in}, 64'd0);
    check("mid_reset_data", {32'd0, data_out_i_in[31:0]}, 64'd0);
    check("mid_reset_tx_cnt", {48'd0, tx_cnt[15:0]}, 64'd0);
    tick();
    check("mid_reset_lost", {63'd0, pndng_i_in[0]}, 64'd0);

    // Packet format and first injection
    push_tx(0, 4'd4, 4'd5, 1'b1, 15'h5555, 1'b1);
    check("tx_format", {32'd0, data_out_i_in[31:0]}, 64'h0045D555);
    check("tx_pndng_after_push", {63'd0, pndng_i_in[0]}, 64'd1);
    pop_tx_head(0, "tx_head_first");
    check("tx_cnt_one", {48'd0, tx_cnt[15:0]}, 64'd1);
    check("tx_empty_after_pop", {63'd0, pndng_i_in[0]}, 64'd0);

    // Fill TX, fifth push dropped silently
    for (int i = 0; i < 4; i++)
      push_tx(0, 4'(i + 1), 4'(i + 2), 1'(i), 15'($urandom_range(0, 32767)), 1'b1);
    check("tx_full_flag", {63'd0, in_full[0]}, 64'd1);
    push_tx(0, 4'hA, 4'hB, 1'b1, 15'h7777, 1'b0);
    check("tx_full_after_drop", {63'd0, in_full[0]}, 64'd1);
    n = 0;
    for (int k = 0; k < 8 && pndng_i_in[0]; k++) begin
      pop_tx_head(0, "tx_drain_order");
      n++;
    end
    check("tx_drain_count", 64'(n), 64'd4);
    check("tx_q_consumed", 64'(tx_q.size()), 64'd0);
    check("tx_cnt_five", {48'd0, tx_cnt[15:0]}, 64'd5);
    check("no_proto_after_drain", {63'd0, proto_err[0]}, 64'd0);

    // RX backpressure on terminal 4 (ID {1,0})
    for (int c = 0; c < 6; c++) begin
      pk = mk(4'd1, 4'd0, 1'b0, 15'($urandom_range(0, 32767)));
      data_out[4*PS +: PS] = pk;
      pndng[4] = 1'b1;
      #1;
      check("rx_popin_fill", {63'd0, popin[4]}, (c < 4) ? 64'd1 : 64'd0);
      if (popin[4]) rx_q.push_back(pk);
      tick();
    end
    check("rx_cnt_four", {48'd0, rx_cnt[4*CW +: CW]}, 64'd4);
    check("rx_valid_full", {63'd0, rx_valid[4]}, 64'd1);
    rx_pop[4] = 1'b1;
    #1;
    check("rx_popin_same_cycle", {63'd0, popin[4]}, 64'd0);
    check("rx_head_while_full", {32'd0, rx_data[4*PS +: PS]}, {32'd0, rx_q.pop_front()});
    tick();
    rx_pop[4] = 1'b0;
    #1;
    check("rx_popin_resume", {63'd0, popin[4]}, 64'd1);
    if (popin[4]) rx_q.push_back(data_out[4*PS +: PS]);
    tick();
    pndng[4] = 1'b0;
    check("rx_cnt_five", {48'd0, rx_cnt[4*CW +: CW]}, 64'd5);
    n = 0;
    for (int k = 0; k < 8 && rx_valid[4]; k++) begin
      pop_rx_head(4, "rx_drain_order");
      n++;
    end
    check("rx_drain_count", 64'(n), 64'd4);
    check("rx_no_misroute", {48'd0, misroute_err}, 64'd0);

    // Destination checking
    deliver_rx(4, mk(4'd2, 4'd5, 1'b0, 15'h1234), "rx_popin_wrong_dest");
    check("misroute_set", {63'd0, misroute_err[4]}, 64'd1);
    pop_rx_head(4, "rx_wrong_dest_data");
    tick();
    check("misroute_sticky", {63'd0, misroute_err[4]}, 64'd1);
    deliver_rx(5, mk(4'hF, 4'hF, 1'b1, 15'h0F0F), "rx_popin_bdcst");
    deliver_rx(12, mk(4'd1, 4'd5, 1'b0, 15'h2222), "rx_popin_t12_own");
    check("misroute_vector", {48'd0, misroute_err}, 64'h0010);
    pop_rx_head(5, "rx_bdcst_data");
    pop_rx_head(12, "rx_t12_data");

    // Protocol errors: pop on empty TX, rx_pop on empty RX
    pop[1] = 1'b1;
    tick();
    pop[1] = 1'b0;
    check("proto_pop_empty", {63'd0, proto_err[1]}, 64'd1);
    check("proto_tx_cnt_held", {48'd0, tx_cnt[1*CW +: CW]}, 64'd0);
    check("proto_pndng_held", {63'd0, pndng_i_in[1]}, 64'd0);
    push_tx(1, 4'd3, 4'd3, 1'b0, 15'h00AA, 1'b0);
    check("proto_ptr_intact", {32'd0, data_out_i_in[1*PS +: PS]}, {32'd0, mk(4'd3, 4'd3, 1'b0, 15'h00AA)});
    rx_pop[2] = 1'b1;
    tick();
    rx_pop[2] = 1'b0;
    check("proto_rx_pop_empty", {63'd0, proto_err[2]}, 64'd1);

    // Push and pop together on an empty TX: only the push happens
    in_row[3*4 +: 4] = 4'd6; in_col[3*4 +: 4] = 4'd2; in_mode[3] = 1'b1;
    in_pyld[3*PWD +: PWD] = 15'h4321;
    in_push[3] = 1'b1;
    pop[3] = 1'b1;
    tick();
    in_push[3] = 1'b0;
    pop[3] = 1'b0;
    check("empty_push_pop_pndng", {63'd0, pndng_i_in[3]}, 64'd1);
    check("empty_push_pop_cnt", {48'd0, tx_cnt[3*CW +: CW]}, 64'd0);
    check("empty_push_pop_data", {32'd0, data_out_i_in[3*PS +: PS]}, {32'd0, mk(4'd6, 4'd2, 1'b1, 15'h4321)});
    check("proto_vector", {48'd0, proto_err}, 64'h000E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
